// File: rtl/capture_rle.sv
// ============================================================================
// Module   : capture_rle
// Brief    : Run-length compressor between the capture stream and sample FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module capture_rle #(
    parameter int SIZE  = 32,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [SIZE-1:0]       s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    output logic [CNT_W+SIZE-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    input  logic                  enable,
    input  logic                  flush,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           words_out
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic [SIZE-1:0]         r_cur_data, w_cur_data_nxt;
    logic [CNT_W-1:0]        r_cur_cnt, w_cur_cnt_nxt;
    logic                    r_flush_pending, w_flush_pending_nxt;
    logic [CNT_W+SIZE-1:0]   r_m_tdata, w_m_tdata_nxt;
    logic                    r_m_tvalid, w_m_tvalid_nxt;
    logic                    r_done, w_done_nxt;
    logic [31:0]             r_words_out;

    logic w_slot_free;
    logic w_accept;
    logic w_merge;

    assign w_slot_free = !r_m_tvalid || m_tready;
    assign s_tready    = reset && w_slot_free && !r_flush_pending;
    assign w_accept    = s_tvalid && s_tready;
    // A saturated run never merges, so a count can never wrap to zero.
    assign w_merge     = enable && (s_tdata == r_cur_data) && (r_cur_cnt != C_CNT_MAX);

    assign m_tdata   = r_m_tdata;
    assign m_tvalid  = r_m_tvalid;
    assign done      = r_done;
    assign words_out = r_words_out;
    assign busy      = (r_state == ST_RUN) || r_m_tvalid || r_flush_pending;

    always_comb begin
        w_state_nxt         = r_state;
        w_cur_data_nxt      = r_cur_data;
        w_cur_cnt_nxt       = r_cur_cnt;
        w_m_tdata_nxt       = r_m_tdata;
        w_m_tvalid_nxt      = r_m_tvalid && !m_tready;
        w_done_nxt          = 1'b0;
        w_flush_pending_nxt = r_flush_pending || flush;

        // s_tready is low while a flush is pending, so the two branches never
        // compete for the output register.
        if (r_flush_pending) begin
            if (w_slot_free) begin
                if (r_state == ST_RUN) begin
                    w_m_tdata_nxt  = {r_cur_cnt, r_cur_data};
                    w_m_tvalid_nxt = 1'b1;
                    w_state_nxt    = ST_EMPTY;
                    w_cur_cnt_nxt  = '0;
                end
                w_flush_pending_nxt = 1'b0;
                w_done_nxt          = 1'b1;
            end
        end else if (w_accept) begin
            if (r_state == ST_RUN && w_merge) begin
                w_cur_cnt_nxt = r_cur_cnt + C_CNT_ONE;
            end else begin
                if (r_state == ST_RUN) begin
                    w_m_tdata_nxt  = {r_cur_cnt, r_cur_data};
                    w_m_tvalid_nxt = 1'b1;
                end
                w_cur_data_nxt = s_tdata;
                w_cur_cnt_nxt  = C_CNT_ONE;
                w_state_nxt    = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state         <= ST_EMPTY;
            r_cur_data      <= '0;
            r_cur_cnt       <= '0;
            r_flush_pending <= 1'b0;
            r_m_tdata       <= '0;
            r_m_tvalid      <= 1'b0;
            r_done          <= 1'b0;
            r_words_out     <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_cur_data      <= w_cur_data_nxt;
            r_cur_cnt       <= w_cur_cnt_nxt;
            r_flush_pending <= w_flush_pending_nxt;
            r_m_tdata       <= w_m_tdata_nxt;
            r_m_tvalid      <= w_m_tvalid_nxt;
            r_done          <= w_done_nxt;
            if (r_m_tvalid && m_tready) begin
                r_words_out <= r_words_out + 32'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_capture_rle.sv
// ============================================================================
// Module   : tb_capture_rle
// Brief    : Directed self-checking bench for capture_rle with a run model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_capture_rle;

    localparam int SIZE = 32;
    localparam int CNT_W = 4;
    localparam int WW = SIZE + CNT_W;
    localparam int MAXC = (1 << CNT_W) - 1;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [SIZE-1:0] s_tdata = '0;
    logic            s_tvalid = 1'b0;
    logic            s_tready;
    logic [WW-1:0]   m_tdata;
    logic            m_tvalid;
    logic            m_tready = 1'b1;
    logic            enable = 1'b1;
    logic            flush = 1'b0;
    logic            busy;
    logic            done;
    logic [31:0]     words_out;

    capture_rle #(.SIZE(SIZE), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .enable(enable), .flush(flush), .busy(busy), .done(done),
        .words_out(words_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int done_cnt = 0;
    int stalls = 0;
    int model_words = 0;
    logic [WW-1:0] expq[$];
    logic [WW-1:0] got[$];
    logic [SIZE-1:0] run_d = '0;
    int run_c = 0;
    logic prev_stall = 1'b0;
    logic [WW-1:0] prev_data = '0;

    function automatic logic [WW-1:0] mk(input int c, input logic [SIZE-1:0] d);
        logic [CNT_W-1:0] cc;
        cc = c[CNT_W-1:0];
        return {cc, d};
    endfunction

    function automatic logic [WW-1:0] got_at(input int i);
        if (i < got.size()) return got[i];
        return '1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: an accepted sample either extends the open run or closes it.
    always @(negedge clk) begin
        if (!reset) begin
            expq.delete();
            run_c = 0;
            model_words = 0;
            prev_stall = 1'b0;
        end else begin
            chk("words_out", 64'(words_out), 64'(model_words));
            if (prev_stall) chk("hold_stable", 64'(m_tdata), 64'(prev_data));
            if (m_tvalid && m_tready) begin
                got.push_back(m_tdata);
                if (expq.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_word: got %0h expected none", m_tdata);
                end else begin
                    chk("out_word", 64'(m_tdata), 64'(expq.pop_front()));
                end
                chk("count_nonzero", 64'(m_tdata[WW-1:SIZE] != 0), 64'd1);
                model_words++;
            end
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            if (s_tvalid && s_tready) begin
                if (run_c > 0 && enable && s_tdata == run_d && run_c < MAXC) begin
                    run_c++;
                end else begin
                    if (run_c > 0) expq.push_back(mk(run_c, run_d));
                    run_d = s_tdata;
                    run_c = 1;
                end
            end
            if (flush) begin
                if (run_c > 0) expq.push_back(mk(run_c, run_d));
                run_c = 0;
            end
            if (done) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_one(input logic [SIZE-1:0] d);
        logic acc;
        acc = 1'b0;
        s_tdata  = d;
        s_tvalid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            acc = s_tready;
            if (!acc) stalls++;
            tick();
            if (acc) break;
        end
        if (!acc) begin
            checks++;
            $display("FAIL send_timeout: got s_tready=0 expected 1 within 100 cycles");
        end
    endtask

    task automatic send_n(input logic [SIZE-1:0] d, input int n);
        for (int i = 0; i < n; i++) send_one(d);
        s_tvalid = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic wait_done();
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            $display("FAIL done_timeout: got no done expected pulse within 100 cycles");
        end
        for (int k = 0; k < 4; k++) tick();
    endtask

    initial begin
        int d0;
        int w0;
        // Reset state
        tick();
        @(negedge clk);
        chk("rst_s_tready", 64'(s_tready), 64'd0);
        tick();
        chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_m_tdata", 64'(m_tdata), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_words_out", 64'(words_out), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        reset = 1'b1;
        tick();

        // Compression
        got.delete();
        d0 = done_cnt;
        send_n(32'hA5, 5);
        send_n(32'h3C, 2);
        do_flush();
        wait_done();
        chk("cmp_nwords", 64'(got.size()), 64'd2);
        chk("cmp_w0", 64'(got_at(0)), 64'({4'd5, 32'hA5}));
        chk("cmp_w1", 64'(got_at(1)), 64'({4'd2, 32'h3C}));
        chk("cmp_done_once", 64'(done_cnt - d0), 64'd1);
        chk("cmp_words_out", 64'(words_out), 64'd2);

        // Bypass
        got.delete();
        enable = 1'b0;
        stalls = 0;
        send_n(32'h7, 3);
        do_flush();
        wait_done();
        enable = 1'b1;
        chk("byp_nwords", 64'(got.size()), 64'd3);
        for (int i = 0; i < 3; i++) chk("byp_word", 64'(got_at(i)), 64'({4'd1, 32'h7}));
        chk("byp_no_stall", 64'(stalls), 64'd0);

        // Saturation
        got.delete();
        send_n(32'h11, 20);
        do_flush();
        wait_done();
        chk("sat_nwords", 64'(got.size()), 64'd2);
        chk("sat_w0", 64'(got_at(0)), 64'({4'd15, 32'h11}));
        chk("sat_w1", 64'(got_at(1)), 64'({4'd5, 32'h11}));

        // Backpressure
        got.delete();
        w0 = int'(words_out);
        m_tready = 1'b0;
        send_one(32'h1);
        send_one(32'h2);
        s_tdata = 32'h3;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("bp_s_tready_low", 64'(s_tready), 64'd0);
            chk("bp_m_tvalid", 64'(m_tvalid), 64'd1);
            chk("bp_m_tdata", 64'(m_tdata), 64'({4'd1, 32'h1}));
            tick();
        end
        m_tready = 1'b1;
        send_one(32'h3);
        s_tvalid = 1'b0;
        tick();
        do_flush();
        wait_done();
        chk("bp_nwords", 64'(got.size()), 64'd3);
        chk("bp_w0", 64'(got_at(0)), 64'({4'd1, 32'h1}));
        chk("bp_w1", 64'(got_at(1)), 64'({4'd1, 32'h2}));
        chk("bp_w2", 64'(got_at(2)), 64'({4'd1, 32'h3}));
        chk("bp_words_out", 64'(int'(words_out) - w0), 64'd3);

        // Flush together with an accepted sample
        got.delete();
        d0 = done_cnt;
        send_n(32'h40, 3);
        s_tdata  = 32'h40;
        s_tvalid = 1'b1;
        flush    = 1'b1;
        @(negedge clk);
        chk("fs_s_tready", 64'(s_tready), 64'd1);
        tick();
        s_tvalid = 1'b0;
        flush    = 1'b0;
        wait_done();
        chk("fs_nwords", 64'(got.size()), 64'd1);
        chk("fs_w0", 64'(got_at(0)), 64'({4'd4, 32'h40}));
        chk("fs_done_once", 64'(done_cnt - d0), 64'd1);
        chk("fs_busy", 64'(busy), 64'd0);

        // Reset mid-run
        got.delete();
        send_n(32'hFF, 9);
        chk("rr_busy_before", 64'(busy), 64'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("rr_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("rr_words_out", 64'(words_out), 64'd0);
        chk("rr_busy", 64'(busy), 64'd0);
        d0 = done_cnt;
        do_flush();
        wait_done();
        chk("rr_nwords", 64'(got.size()), 64'd0);
        chk("rr_done", 64'(done_cnt - d0), 64'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
